cram_arbiter: RTL and testbench
===============================

Name: cram_arbiter

Overview:
- Shares the single-port cartridge RAM between two requesters: the running game's MBC cart-RAM accesses (CPU side) and the HPS backup/save-file path (bk side).
- The CPU side has absolute priority and is never stalled.
- The bk side uses 16-bit word transfers. The arbiter splits each word into two byte accesses, retries any byte that loses arbitration, and completes with a req/ack handshake.
- Sits between the mapper's cram_addr/cram_di/cram_do signals and the cart RAM block.

Parameters:
- ADDR_W, 17, cart RAM byte-address width.
- BK_AW, 16, bk word-address width; must equal ADDR_W-1.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce_cpu  in  1  CPU clock enable; CPU side is sampled only when high
- cpu_req  in  1  CPU cart-RAM access this ce_cpu cycle (already nCS/enable-qualified)
- cpu_wr  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_di  in  8  CPU write data
- cpu_do  out  8  CPU read data, registered
- bk_req  in  1  bk transfer request; held high until bk_ack
- bk_wr  in  1  1 = write word, 0 = read word
- bk_addr  in  BK_AW  word address
- bk_wdata  in  16  write word
- bk_rdata  out  16  read word, valid when bk_ack is high
- bk_ack  out  1  one-cycle completion pulse
- ram_enabled  in  1  mapper RAM-enable state (used only by the optional feature)
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write strobe
- ram_d  out  8  RAM write data
- ram_q  in  8  RAM read data; one-cycle latency from ram_addr

Behaviour:
- Reset values:
  - cpu_do = 8'hFF; bk_rdata = 0; bk_ack = 0.
  - ram_we = 0; ram_addr = 0; ram_d = 0.
  - FSM = IDLE; owner_q = NONE.
- Reset asserted mid-transfer aborts the transfer with no ack and no further RAM writes. The requester must re-present bk_req after reset.
- Each clock is one RAM slot. Slot grant is combinational:
  - CPU gets the slot if ce_cpu & cpu_req.
  - Otherwise the bk FSM gets it if it is in BK_LO or BK_HI.
  - Otherwise the slot is idle.
- CPU slot:
  - ram_addr = cpu_addr.
  - ram_we = cpu_wr; ram_d = cpu_di.
  - For reads, owner_q <= CPU, and the next cycle captures cpu_do <= ram_q.
  - cpu_do holds its value until the next CPU read capture.
  - Read latency is 2 clocks from the ce_cpu request to cpu_do valid.
- bk FSM states: IDLE, BK_LO, BK_HI, DONE.
  - IDLE -> BK_LO when bk_req is high and bk_ack is low. Address and direction are latched at this point; bk_addr/bk_wr changes after this are ignored.
  - BK_LO: slot address = {addr, 1'b0}, data = bk_wdata[7:0]. When the slot is granted, go to BK_HI.
  - BK_HI: slot address = {addr, 1'b1}, data = bk_wdata[15:8]. When the slot is granted, go to DONE.
  - If the slot is not granted, the FSM stays in its state and retries the same byte next cycle.
  - Read capture: bk_rdata[7:0] is captured the cycle after the BK_LO grant; bk_rdata[15:8] the cycle after the BK_HI grant. owner_q tags the capture so a CPU slot in between cannot corrupt it.
  - DONE waits for the pending read capture, then pulses bk_ack for one cycle and returns to IDLE.
  - Minimum latency from bk_req to bk_ack is 4 clocks when there is no contention.
- Simultaneous CPU and bk request in the same cycle: the CPU wins and the bk byte is deferred. A CPU write to the same address as a pending bk byte takes effect first.
- Starvation: bk progress is guaranteed while ce_cpu is high in at most 1 of every 2 clocks, which holds system-wide. There is no timeout.
- Address wrap: {addr, 1} for addr = all-ones is 2^ADDR_W - 1. There is no carry across the word.

Optional Feature:
- Macro: CRAM_ARB_WRLOCK_EN.
- Defined:
  - A bk write latched while ram_enabled = 1 skips both RAM slots. The FSM goes BK_LO -> BK_HI -> DONE with ram_we held low, and bk_ack still pulses.
  - bk reads are unaffected.
  - A 1-bit output bk_wr_blocked is added. It is high together with bk_ack for a suppressed write.
- Undefined: ram_enabled is ignored, bk writes always reach RAM, and the bk_wr_blocked port is absent.

Decomposition:
- Shared package (cram_arb_pkg):
  - FSM state enum (IDLE, BK_LO, BK_HI, DONE).
  - Owner enum (NONE, CPU, BK_LO, BK_HI).
  - Reset constant CPU_DO_RST = 8'hFF.
- Sub-module: cram_slot_mux, combinational grant plus address/data/we mux.
- The FSM and capture registers stay in the top module.

Test Plan:
- bk write 0x1234 to word 0x0005, no CPU traffic -> RAM[0x000A]=0x34 and RAM[0x000B]=0x12 written on consecutive clocks; bk_ack at clock 4.
- CPU read of 0x000B with ce_cpu every 4th clock, after the previous write -> cpu_do=0x12 two clocks after the request; cpu_do holds it across later idle cycles.
- bk read of word 0x0005 with a CPU read of 0x0100 (RAM=0xAA) colliding on the BK_HI cycle -> BK_HI retried next clock; bk_rdata=0x1234; cpu_do=0xAA; bk_ack at clock 5.
- CPU write 0x55 to 0x000A in the same cycle bk BK_LO writes 0x77 there -> CPU first, then bk retry; final RAM[0x000A]=0x77.
- reset asserted during BK_HI of a write -> no bk_ack; RAM[odd byte] unchanged; cpu_do=0xFF; FSM in IDLE after release.
- With CRAM_ARB_WRLOCK_EN and ram_enabled=1: bk write 0xBEEF -> no ram_we pulses; bk_ack and bk_wr_blocked pulse together; RAM unchanged.

Source files
------------

// File: rtl/cram_arb_pkg.sv
// Shared types and constants for the cart-RAM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package cram_arb_pkg;

    // bk word-transfer sequencer
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BK_LO = 2'd1,
        ST_BK_HI = 2'd2,
        ST_DONE  = 2'd3
    } bk_state_t;

    // Which requester owns the read data returning from RAM this cycle
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_CPU   = 2'd1,
        OWN_BK_LO = 2'd2,
        OWN_BK_HI = 2'd3
    } owner_t;

    localparam logic [7:0] CPU_DO_RST = 8'hFF;

endpackage

// File: rtl/cram_slot_mux.sv
// Per-clock RAM slot grant and address/data/write-strobe mux (CPU over bk).
// Latency: purely combinational, zero cycles.
// Backpressure: CPU is never refused; a bk byte that loses simply sees bk_grant low.
module cram_slot_mux #(
    parameter int ADDR_W = 17
) (
    input  logic              slot_en,
    input  logic              cpu_sel,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_di,
    input  logic              bk_sel,
    input  logic              bk_hi,
    input  logic              bk_we,
    input  logic [ADDR_W-2:0] bk_addr,
    input  logic [15:0]       bk_wdata,
    output logic              cpu_grant,
    output logic              bk_grant,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_d
);

    // Grant the slot and steer the winner onto the RAM port; idle slot drives zeros
    always_comb begin
        cpu_grant = slot_en & cpu_sel;
        bk_grant  = slot_en & bk_sel & ~cpu_sel;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_d     = 8'h00;
        if (cpu_grant) begin
            ram_addr = cpu_addr;
            ram_we   = cpu_wr;
            ram_d    = cpu_di;
        end else if (bk_grant) begin
            // no carry into the next word: odd byte is just the LSB set
            ram_addr = {bk_addr, bk_hi};
            ram_we   = bk_we;
            ram_d    = bk_hi ? bk_wdata[15:8] : bk_wdata[7:0];
        end
    end

endmodule

// File: rtl/cram_arbiter.sv
// Shares single-port cart RAM between the CPU (absolute priority) and the bk 16-bit word path.
// Latency: CPU read data 2 clk after request; bk ack 4 clk after bk_req when uncontended.
// Backpressure: CPU never stalls; bk bytes retry each clock until granted, bk_req held to bk_ack.
// Optional: CRAM_ARB_WRLOCK_EN suppresses bk writes latched while ram_enabled=1 (adds bk_wr_blocked).
module cram_arbiter
    import cram_arb_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int BK_AW  = 16   // must equal ADDR_W-1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce_cpu,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_di,
    output logic [7:0]        cpu_do,
    input  logic              bk_req,
    input  logic              bk_wr,
    input  logic [BK_AW-1:0]  bk_addr,
    input  logic [15:0]       bk_wdata,
    output logic [15:0]       bk_rdata,
    output logic              bk_ack,
`ifdef CRAM_ARB_WRLOCK_EN
    output logic              bk_wr_blocked,
`endif
    input  logic              ram_enabled,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_d,
    input  logic [7:0]        ram_q
);

    bk_state_t        state, state_nxt;
    owner_t           owner_q, owner_nxt;
    logic [BK_AW-1:0] bk_addr_q;
    logic             bk_wr_q;
    logic             blocked_q;
    logic             cpu_grant, bk_grant;
    logic             bk_we;
    logic             latch_req;

`ifdef CRAM_ARB_WRLOCK_EN
    logic             blocked_in;
    assign blocked_in = bk_wr & ram_enabled;
`else
    logic             blocked_in;
    logic             unused_ram_enabled;
    assign blocked_in         = 1'b0;
    assign unused_ram_enabled = ram_enabled;
`endif

    assign bk_we     = bk_wr_q & ~blocked_q;
    assign latch_req = (state == ST_IDLE) & bk_req & ~bk_ack;

    // reset also idles the slot so nothing reaches the RAM while it is held
    cram_slot_mux #(.ADDR_W(ADDR_W)) u_slot_mux (
        .slot_en   (~reset),
        .cpu_sel   (ce_cpu & cpu_req),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_di    (cpu_di),
        .bk_sel    ((state == ST_BK_LO) || (state == ST_BK_HI)),
        .bk_hi     (state == ST_BK_HI),
        .bk_we     (bk_we),
        .bk_addr   (bk_addr_q),
        .bk_wdata  (bk_wdata),
        .cpu_grant (cpu_grant),
        .bk_grant  (bk_grant),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_d     (ram_d)
    );

    // Next state and read-owner tag for the slot in flight
    always_comb begin
        state_nxt = state;
        owner_nxt = OWN_NONE;
        case (state)
            ST_IDLE:  if (latch_req) state_nxt = ST_BK_LO;
            ST_BK_LO: if (bk_grant)  state_nxt = ST_BK_HI;
            ST_BK_HI: if (bk_grant)  state_nxt = ST_DONE;
            // DONE is only entered from a BK_HI grant, so the high-byte
            // capture lands on the same edge that raises bk_ack
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (cpu_grant && !cpu_wr) begin
            owner_nxt = OWN_CPU;
        end else if (bk_grant && !bk_wr_q) begin
            owner_nxt = (state == ST_BK_HI) ? OWN_BK_HI : OWN_BK_LO;
        end
    end

    // State, owner tag and latched bk command
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner_q   <= OWN_NONE;
            bk_addr_q <= '0;
            bk_wr_q   <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            owner_q <= owner_nxt;
            if (latch_req) begin
                bk_addr_q <= bk_addr;
                bk_wr_q   <= bk_wr;
                blocked_q <= blocked_in;
            end
        end
    end

    // Steer returning RAM data to whoever issued the read last cycle; pulse ack out of DONE
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cpu_do   <= CPU_DO_RST;
            bk_rdata <= 16'h0000;
            bk_ack   <= 1'b0;
        end else begin
            case (owner_q)
                OWN_CPU:   cpu_do         <= ram_q;
                OWN_BK_LO: bk_rdata[7:0]  <= ram_q;
                OWN_BK_HI: bk_rdata[15:8] <= ram_q;
                default:   ;
            endcase
            bk_ack <= (state == ST_DONE);
        end
    end

`ifdef CRAM_ARB_WRLOCK_EN
    // Flag a suppressed write alongside its ack
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            bk_wr_blocked <= 1'b0;
        end else begin
            bk_wr_blocked <= (state == ST_DONE) & blocked_q;
        end
    end
`endif

endmodule

// File: tb/tb_cram_arbiter.sv
// Directed self-checking bench for cram_arbiter with a behavioural 1-cycle-latency RAM.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_cram_arbiter;

    localparam int ADDR_W = 17;
    localparam int BK_AW  = 16;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              ce_cpu, cpu_req, cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_di, cpu_do;
    logic              bk_req, bk_wr;
    logic [BK_AW-1:0]  bk_addr;
    logic [15:0]       bk_wdata, bk_rdata;
    logic              bk_ack;
`ifdef CRAM_ARB_WRLOCK_EN
    logic              bk_wr_blocked;
`endif
    logic              ram_enabled;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_d, ram_q;

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    int total = 0;
    int bad   = 0;

    always #5 clk_sys = ~clk_sys;

    // Single-port RAM, read-before-write, one clock read latency
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_d;
        ram_q <= mem[ram_addr];
    end

    cram_arbiter #(.ADDR_W(ADDR_W), .BK_AW(BK_AW)) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ce_cpu        (ce_cpu),
        .cpu_req       (cpu_req),
        .cpu_wr        (cpu_wr),
        .cpu_addr      (cpu_addr),
        .cpu_di        (cpu_di),
        .cpu_do        (cpu_do),
        .bk_req        (bk_req),
        .bk_wr         (bk_wr),
        .bk_addr       (bk_addr),
        .bk_wdata      (bk_wdata),
        .bk_rdata      (bk_rdata),
        .bk_ack        (bk_ack),
`ifdef CRAM_ARB_WRLOCK_EN
        .bk_wr_blocked (bk_wr_blocked),
`endif
        .ram_enabled   (ram_enabled),
        .ram_addr      (ram_addr),
        .ram_we        (ram_we),
        .ram_d         (ram_d),
        .ram_q         (ram_q)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic cpu_idle();
        ce_cpu  = 1'b0;
        cpu_req = 1'b0;
        cpu_wr  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_idle();
        cpu_addr = '0; cpu_di = 8'h00;
        bk_req = 1'b0; bk_wr = 1'b0; bk_addr = '0; bk_wdata = 16'h0000;
        ram_enabled = 1'b0;
        tick(); tick();
        total++; if (cpu_do !== 8'hFF) begin bad++; $display("FAIL rst_cpu_do: got %h want ff", cpu_do); end
        total++; if (bk_rdata !== 16'h0000) begin bad++; $display("FAIL rst_bk_rdata: got %h want 0000", bk_rdata); end
        total++; if (bk_ack !== 1'b0) begin bad++; $display("FAIL rst_bk_ack: got %b want 0", bk_ack); end
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
        total++; if (ram_addr !== 17'h00000) begin bad++; $display("FAIL rst_ram_addr: got %h want 0", ram_addr); end
        total++; if (ram_d !== 8'h00) begin bad++; $display("FAIL rst_ram_d: got %h want 00", ram_d); end
        reset = 1'b0;
        tick();
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL post_rst_idle_we: got %b want 0", ram_we); end
    endtask

    task automatic test_cpu_write();
        ce_cpu = 1'b1; cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 17'h00100; cpu_di = 8'hAA;
        #1;
        total++; if (ram_we !== 1'b1 || ram_addr !== 17'h00100) begin bad++; $display("FAIL cpu_wr_slot: got we=%b addr=%h want we=1 addr=00100", ram_we, ram_addr); end
        tick();
        cpu_idle();
        total++; if (mem[17'h00100] !== 8'hAA) begin bad++; $display("FAIL cpu_wr_mem: got %h want aa", mem[17'h00100]); end
    endtask

    task automatic test_bk_write();
        bk_req = 1'b1; bk_wr = 1'b1; bk_addr = 16'h0005; bk_wdata = 16'h1234;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) begin
                total++; if (ram_we !== 1'b1 || ram_addr !== 17'h0000A || ram_d !== 8'h34) begin bad++; $display("FAIL bkw_lo_slot: got we=%b addr=%h d=%h want 1 0000a 34", ram_we, ram_addr, ram_d); end
            end else if (c == 2) begin
                total++; if (ram_we !== 1'b1 || ram_addr !== 17'h0000B || ram_d !== 8'h12) begin bad++; $display("FAIL bkw_hi_slot: got we=%b addr=%h d=%h want 1 0000b 12", ram_we, ram_addr, ram_d); end
            end
            if (c < 4) begin
                total++; if (bk_ack !== 1'b0) begin bad++; $display("FAIL bkw_early_ack: clock %0d got %b want 0", c, bk_ack); end
            end else begin
                total++; if (bk_ack !== 1'b1) begin bad++; $display("FAIL bkw_ack_clk4: got %b want 1", bk_ack); end
`ifdef CRAM_ARB_WRLOCK_EN
                total++; if (bk_wr_blocked !== 1'b0) begin bad++; $display("FAIL bkw_not_blocked: got %b want 0", bk_wr_blocked); end
`endif
            end
        end
        bk_req = 1'b0;
        tick();
        total++; if (bk_ack !== 1'b0) begin bad++; $display("FAIL bkw_ack_pulse: got %b want 0", bk_ack); end
        total++; if (mem[17'h0000A] !== 8'h34 || mem[17'h0000B] !== 8'h12) begin bad++; $display("FAIL bkw_mem: got %h %h want 34 12", mem[17'h0000A], mem[17'h0000B]); end
    endtask

    task automatic test_cpu_read();
        ce_cpu = 1'b1; cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 17'h0000B;
        tick();
        cpu_idle();
        total++; if (cpu_do !== 8'hFF) begin bad++; $display("FAIL cpu_rd_clk1: got %h want ff", cpu_do); end
        tick();
        total++; if (cpu_do !== 8'h12) begin bad++; $display("FAIL cpu_rd_clk2: got %h want 12", cpu_do); end
        tick(); tick();
        ce_cpu = 1'b1;
        tick();
        ce_cpu = 1'b0;
        tick();
        total++; if (cpu_do !== 8'h12) begin bad++; $display("FAIL cpu_rd_hold: got %h want 12", cpu_do); end
    endtask

    task automatic test_bk_read_collide();
        bk_req = 1'b1; bk_wr = 1'b0; bk_addr = 16'h0005;
        tick(); tick();
        ce_cpu = 1'b1; cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 17'h00100;
        #1;
        total++; if (ram_addr !== 17'h00100 || ram_we !== 1'b0) begin bad++; $display("FAIL bkr_cpu_wins: got addr=%h we=%b want 00100 0", ram_addr, ram_we); end
        tick();
        cpu_idle();
        #1;
        total++; if (ram_addr !== 17'h0000B) begin bad++; $display("FAIL bkr_hi_retry: got %h want 0000b", ram_addr); end
        tick();
        total++; if (cpu_do !== 8'hAA) begin bad++; $display("FAIL bkr_cpu_do: got %h want aa", cpu_do); end
        total++; if (bk_ack !== 1'b0) begin bad++; $display("FAIL bkr_early_ack: got %b want 0", bk_ack); end
        tick();
        total++; if (bk_ack !== 1'b1) begin bad++; $display("FAIL bkr_ack_clk5: got %b want 1", bk_ack); end
        total++; if (bk_rdata !== 16'h1234) begin bad++; $display("FAIL bkr_rdata: got %h want 1234", bk_rdata); end
        bk_req = 1'b0;
        tick();
    endtask

    task automatic test_write_collide();
        bk_req = 1'b1; bk_wr = 1'b1; bk_addr = 16'h0005; bk_wdata = 16'h6677;
        tick();
        ce_cpu = 1'b1; cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 17'h0000A; cpu_di = 8'h55;
        #1;
        total++; if (ram_d !== 8'h55) begin bad++; $display("FAIL wcol_cpu_first: got %h want 55", ram_d); end
        tick();
        cpu_idle();
        #1;
        total++; if (mem[17'h0000A] !== 8'h55) begin bad++; $display("FAIL wcol_cpu_mem: got %h want 55", mem[17'h0000A]); end
        total++; if (ram_d !== 8'h77 || ram_addr !== 17'h0000A) begin bad++; $display("FAIL wcol_bk_retry: got d=%h addr=%h want 77 0000a", ram_d, ram_addr); end
        tick(); tick(); tick();
        total++; if (bk_ack !== 1'b1) begin bad++; $display("FAIL wcol_ack_clk5: got %b want 1", bk_ack); end
        bk_req = 1'b0;
        tick();
        total++; if (mem[17'h0000A] !== 8'h77 || mem[17'h0000B] !== 8'h66) begin bad++; $display("FAIL wcol_final_mem: got %h %h want 77 66", mem[17'h0000A], mem[17'h0000B]); end
    endtask

    task automatic test_reset_abort();
        bk_req = 1'b1; bk_wr = 1'b1; bk_addr = 16'h0005; bk_wdata = 16'h9988;
        tick(); tick();
        reset = 1'b1;
        bk_req = 1'b0;
        #1;
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rab_we_in_rst: got %b want 0", ram_we); end
        tick(); tick();
        total++; if (bk_ack !== 1'b0) begin bad++; $display("FAIL rab_no_ack: got %b want 0", bk_ack); end
        total++; if (mem[17'h0000B] !== 8'h66 || mem[17'h0000A] !== 8'h88) begin bad++; $display("FAIL rab_mem: got %h %h want 88 66", mem[17'h0000A], mem[17'h0000B]); end
        total++; if (cpu_do !== 8'hFF || bk_rdata !== 16'h0000) begin bad++; $display("FAIL rab_regs: got cpu_do=%h bk_rdata=%h want ff 0000", cpu_do, bk_rdata); end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (ram_we !== 1'b0 || bk_ack !== 1'b0) begin bad++; $display("FAIL rab_idle_after: clock %0d got we=%b ack=%b want 0 0", c, ram_we, bk_ack); end
        end
        bk_req = 1'b1; bk_wr = 1'b0; bk_addr = 16'h0005;
        tick(); tick(); tick();
        total++; if (bk_ack !== 1'b0) begin bad++; $display("FAIL rab_new_early_ack: got %b want 0", bk_ack); end
        tick();
        total++; if (bk_ack !== 1'b1 || bk_rdata !== 16'h6688) begin bad++; $display("FAIL rab_new_read: got ack=%b data=%h want 1 6688", bk_ack, bk_rdata); end
        bk_req = 1'b0;
        tick();
    endtask

    task automatic test_wrlock();
        logic [7:0] s0, s1;
        s0 = mem[17'h0000E];
        s1 = mem[17'h0000F];
        ram_enabled = 1'b1;
        bk_req = 1'b1; bk_wr = 1'b1; bk_addr = 16'h0007; bk_wdata = 16'hBEEF;
        for (int c = 1; c <= 4; c++) begin
            tick();
`ifdef CRAM_ARB_WRLOCK_EN
            total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL wl_no_we: clock %0d got %b want 0", c, ram_we); end
            if (c == 4) begin
                total++; if (bk_ack !== 1'b1 || bk_wr_blocked !== 1'b1) begin bad++; $display("FAIL wl_ack_blocked: got ack=%b blk=%b want 1 1", bk_ack, bk_wr_blocked); end
            end
`else
            if (c == 4) begin
                total++; if (bk_ack !== 1'b1) begin bad++; $display("FAIL wl_off_ack: got %b want 1", bk_ack); end
            end
`endif
        end
        bk_req = 1'b0;
        ram_enabled = 1'b0;
        tick();
`ifdef CRAM_ARB_WRLOCK_EN
        total++; if (mem[17'h0000E] !== s0 || mem[17'h0000F] !== s1) begin bad++; $display("FAIL wl_mem_unchanged: got %h %h want %h %h", mem[17'h0000E], mem[17'h0000F], s0, s1); end
        total++; if (bk_wr_blocked !== 1'b0) begin bad++; $display("FAIL wl_blocked_pulse: got %b want 0", bk_wr_blocked); end
`else
        total++; if (mem[17'h0000E] !== 8'hEF || mem[17'h0000F] !== 8'hBE) begin bad++; $display("FAIL wl_off_mem: got %h %h want ef be (prior %h %h)", mem[17'h0000E], mem[17'h0000F], s0, s1); end
`endif
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_bk_write();
        test_cpu_read();
        test_bk_read_collide();
        test_write_collide();
        test_reset_abort();
        test_wrlock();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
